// File: rtl/synth_arb_mc.sv
`default_nettype none
// ============================================================================
// Module      : synth_arb_mc
// Description : Round-robin sequencer for NUM_OPS synth operators. Each slot
//               steps an operator, waits for output FIFO space, and issues a
//               FIFO write strobe. Memory-bus register writes are queued, and
//               at most one queued write is decoded into a synth command
//               between operator slots.
// Revision    : 1.0  initial release
// ============================================================================
module synth_arb_mc #(
  parameter  int NUM_OPS    = 4,
  parameter  int DATA_W     = 8,
  parameter  int REQ_DEPTH  = 4,
  parameter  int RESET_WAIT = 16,
  localparam int c_OP_W     = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        memadrs,
  input  logic [DATA_W-1:0] memdata,
  input  logic              wreq,
  input  logic              fifo_full,
  output logic [7:0]        synth_ctrl,
  output logic [DATA_W-1:0] synth_data,
  output logic [c_OP_W-1:0] synth_op,
  output logic              frame_strb,
  output logic              req_full,
  output logic              req_err
);

  localparam int c_PTR_W  = $clog2(REQ_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_WAIT_W = (RESET_WAIT > 1) ? $clog2(RESET_WAIT) : 1;
  localparam int c_ENT_W  = 8 + DATA_W;
  localparam logic [c_OP_W-1:0]   c_LAST_OP  = c_OP_W'(NUM_OPS - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_END = c_WAIT_W'(RESET_WAIT - 1);
  localparam logic [c_CNT_W-1:0]  c_DEPTH    = c_CNT_W'(REQ_DEPTH);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_STEP  = 3'd1,
    S_FCHK  = 3'd2,
    S_WRITE = 3'd3,
    S_WWAIT = 3'd4,
    S_CHECK = 3'd5,
    S_CMD   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_OP_W-1:0]     r_k;
  logic [c_WAIT_W-1:0]   r_wait_cnt;
  logic                  r_wreq_d;

  // Request queue storage and bookkeeping
  logic [c_ENT_W-1:0]    r_q_mem [REQ_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_CNT_W-1:0]    w_count_nxt;
  logic                  w_push, w_pop, w_accept, w_drop, w_empty, w_full;
  logic [c_ENT_W-1:0]    w_head;
  logic [3:0]            w_hi, w_lo;
  logic                  w_lo_ok;

  // Decoded command for the queue head
  logic [2:0]            w_dec_cmd;
  logic                  w_dec_act;
  logic [c_OP_W-1:0]     w_dec_op;
  logic                  w_dec_bad;

  // Values to be registered onto the outputs
  logic [7:0]            w_ctrl;
  logic [c_OP_W-1:0]     w_op;
  logic                  w_frame, w_load_data, w_cmd_bad, w_k_adv, w_wait_inc;

  assign w_push   = wreq && !r_wreq_d;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_DEPTH);
  assign w_pop    = (r_state == S_DONE) && !w_empty;
  // A full queue still accepts a push when the head leaves in the same cycle
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;
  assign w_head   = r_q_mem[r_rd_ptr];
  assign w_hi     = w_head[c_ENT_W-1 -: 4];
  assign w_lo     = w_head[c_ENT_W-5 -: 4];
  assign w_lo_ok  = (w_lo != 4'd0) && (int'(w_lo) <= NUM_OPS);

  // Next queue occupancy
  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_pop) begin
      w_count_nxt = r_count + c_CNT_W'(1);
    end else if (!w_accept && w_pop) begin
      w_count_nxt = r_count - c_CNT_W'(1);
    end
  end

  // Queue entry storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_mem[r_wr_ptr] <= {memadrs, memdata};
    end
  end

  // Queue pointers, occupancy and wreq edge register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wreq_d <= 1'b0;
    end else begin
      r_wreq_d <= wreq;
      r_count  <= w_count_nxt;
      if (w_accept) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
    end
  end

  // Address decode of the queue head into a synth command
  always_comb begin
    w_dec_cmd = 3'b000;
    w_dec_act = 1'b0;
    w_dec_op  = '0;
    w_dec_bad = 1'b0;
    case (w_hi)
      4'h0, 4'h1, 4'h2: begin
        if (w_lo_ok) begin
          w_dec_cmd = (w_hi == 4'h0) ? 3'b100 : ((w_hi == 4'h1) ? 3'b001 : 3'b101);
          w_dec_act = 1'b1;
          w_dec_op  = c_OP_W'(w_lo - 4'd1);
        end else begin
          w_dec_bad = 1'b1;
        end
      end
      4'h8:    w_dec_cmd = 3'b010;
      default: w_dec_bad = 1'b1;
    endcase
  end

  // Slot sequencer: next state and the output values for the current state
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = 8'h00;
    w_op        = r_k;
    w_frame     = 1'b0;
    w_load_data = 1'b0;
    w_cmd_bad   = 1'b0;
    w_k_adv     = 1'b0;
    w_wait_inc  = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (r_wait_cnt == c_WAIT_END) w_state_nxt = S_STEP;
        else                          w_wait_inc  = 1'b1;
      end
      S_STEP: begin
        w_ctrl      = 8'h01;
        w_state_nxt = S_FCHK;
      end
      S_FCHK: begin
        if (!fifo_full) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_ctrl      = 8'h81;
        w_frame     = (r_k == c_LAST_OP);
        w_state_nxt = S_WWAIT;
      end
      S_WWAIT: w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (!w_empty) begin
          w_state_nxt = S_CMD;
        end else begin
          w_k_adv     = 1'b1;
          w_state_nxt = S_STEP;
        end
      end
      S_CMD: begin
        w_ctrl      = {1'b0, w_dec_cmd, 3'b000, w_dec_act};
        w_op        = w_dec_op;
        w_load_data = 1'b1;
        w_cmd_bad   = w_dec_bad;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_k_adv     = 1'b1;
        w_state_nxt = S_STEP;
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // FSM state, operator index and reset-recovery counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_WAIT;
      r_k        <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_k_adv) r_k <= (r_k == c_LAST_OP) ? '0 : r_k + c_OP_W'(1);
      if (w_wait_inc) r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
      else            r_wait_cnt <= '0;
    end
  end

  // Registered outputs; synth_data and req_err hold between updates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      synth_ctrl <= 8'h00;
      synth_data <= '0;
      synth_op   <= '0;
      frame_strb <= 1'b0;
      req_full   <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      synth_ctrl <= w_ctrl;
      synth_op   <= w_op;
      frame_strb <= w_frame;
      req_full   <= (w_count_nxt == c_DEPTH);
      if (w_load_data) synth_data <= w_head[DATA_W-1:0];
      if (w_drop || w_cmd_bad) req_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/synth_arb_mc.md
# synth_arb_mc

Multi-operator successor of the single-operator synth arbiter. It sequences N synth operators round-robin: step the operator, wait for output FIFO space, issue a FIFO write strobe. Register writes from the memory bus are queued in a small request buffer instead of an edge latch. Between operator slots it decodes at most one queued write into a synth command. The block sits between the CPU/memory-mapped register port and the operator datapath plus output FIFO.

## Interface
- NUM_OPS, 4, number of operators sequenced (1..15)
- DATA_W, 8, width of register write data and synth_data
- REQ_DEPTH, 4, request-queue entries (power of two, ≥2)
- RESET_WAIT, 16, recovery cycles after reset before sequencing starts (≥1)
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- memadrs  in  8  register address, sampled with wreq
- memdata  in  DATA_W  register data, sampled with wreq
- wreq  in  1  write request level, synchronous to clk; a 0→1 transition is one request
- fifo_full  in  1  output FIFO full
- synth_ctrl  out  8  [7] FIFO write strobe, [6:4] command, [3:1] always 0, [0] operator active
- synth_data  out  DATA_W  command data
- synth_op  out  $clog2(NUM_OPS) (min 1)  operator index qualifying synth_ctrl
- frame_strb  out  1  one-cycle pulse with the FIFO write of operator NUM_OPS-1
- req_full  out  1  request queue full
- req_err  out  1  sticky: request dropped (queue overflow or undecodable address)

## Operation
- Reset values: synth_ctrl=0, synth_data=0, synth_op=0, frame_strb=0, req_full=0, req_err=0. On reset the queue is emptied, the wreq edge register is cleared, the operator index is set to 0, and the FSM enters WAIT.
- Edge detect: wreq_d is the registered wreq. A push occurs when wreq && !wreq_d. The push captures {memadrs, memdata} from that same cycle.
- Push while queue full with no pop that cycle: entry is dropped and req_err is set. Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
- Decode at CMD, using hi=adrs[7:4] and lo=adrs[3:0]:
  - hi 0 → cmd 3'b100, ctrl[0]=1
  - hi 1 → cmd 3'b001, ctrl[0]=1
  - hi 2 → cmd 3'b101, ctrl[0]=1
  - hi 4'b1000 → cmd 3'b010, ctrl[0]=0 (global; lo ignored; synth_op=0)
  - For hi 0/1/2, lo must be 1..NUM_OPS and synth_op=lo-1.
  - Any other address outputs ctrl=0, sets req_err, and still pops the entry.
- FSM (one state per cycle unless stalled):
  - WAIT: count to RESET_WAIT-1, then go to STEP.
  - STEP: ctrl=8'h01, synth_op=k. Next state FCHK.
  - FCHK: ctrl=0. Stay while fifo_full=1, otherwise go to WRITE.
  - WRITE: ctrl=8'h81, synth_op=k. frame_strb=1 if k==NUM_OPS-1. Next state WWAIT.
  - WWAIT: ctrl=0. Next state CHECK.
  - CHECK: ctrl=0. If queue non-empty go to CMD; otherwise set k=(k+1) mod NUM_OPS and go to STEP.
  - CMD: synth_data=head data, ctrl/op per decode. Next state DONE.
  - DONE: ctrl=0, pop head, k=(k+1) mod NUM_OPS, next state STEP. synth_data holds its value.
  - Undefined state encoding goes to WAIT.
- At most one command per operator slot; the queue drains across slots in FIFO order.
- fifo_full is sampled only in FCHK. Changes in other states are ignored.
- req_full = (occupancy == REQ_DEPTH), registered.

## Timing
- All outputs are registered.
- Unstalled slot: 5 cycles with no command (STEP, FCHK, WRITE, WWAIT, CHECK); 7 cycles with a command.
- First STEP is asserted on cycle RESET_WAIT+1 after reset_n rises (1 cycle WAIT entry plus RESET_WAIT count).
- Request latency: the push is visible to CHECK the cycle after the wreq edge. A push landing in CHECK itself is serviced in the next slot.
- Holding wreq high produces one request. Wreq must return low for ≥1 cycle before the next request.
- Asserting reset_n low mid-slot or mid-command clears outputs asynchronously. Queued requests are lost.

## Test plan
- Reset, NUM_OPS=4, fifo_full=0, no wreq → first 8'h01 at cycle 17. Operator sequence 0,1,2,3,0 at 5-cycle spacing. frame_strb pulses with op 3 WRITE (8'h81).
- fifo_full held 1 for 10 cycles in FCHK → ctrl=0 for 10 cycles, then 8'h81 for the same op; no skipped operator.
- wreq pulse with adrs 8'h12, data 8'h5A → in the next CMD: synth_data=8'h5A, ctrl=8'h11, synth_op=1; next cycle ctrl=0.
- Five back-to-back requests (REQ_DEPTH=4) before any CHECK → req_full=1, req_err=1. The first four are serviced in order in four consecutive slots; the fifth is absent.
- adrs 8'h85, data 8'h33 → ctrl=8'h20, synth_op=0. adrs 8'h07 (lo > NUM_OPS) → ctrl=0, req_err=1, entry popped.
- Assert reset_n low during CMD → all outputs 0 immediately. After release: WAIT runs again, queue is empty, no command is issued.
